axi_stream_itof: RTL

Pipelined AXI4-stream signed-int32 to IEEE-754 binary32 converter. Sits directly downstream of the FP dispatch unit's `itof_*` channel: it consumes the integer operand driven on `itof_tdata/itof_tvalid` and returns the converted float on `itof_r_tdata/itof_r_tvalid` under `itof_r_tready` backpressure. It takes one operand per cycle, with fixed 3-cycle latency when unstalled, and stalls the whole pipeline on output backpressure.

---
 rtl/axi_stream_itof_pkg.sv | 22 ++
 rtl/lzc32.sv | 12 +
 rtl/axi_stream_itof.sv | 77 +++++++
 3 files changed

// File: rtl/axi_stream_itof_pkg.sv
// axi_stream_itof_pkg: binary32 constants and pipeline stage records for the int-to-float converter
package axi_stream_itof_pkg;
    localparam int FP32_BIAS     = 127;
    localparam int ITOF_EXP_BASE = FP32_BIAS + 31;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_FRAC_W   = 23;

    typedef struct packed {
        logic        v;
        logic        sign;
        logic        zero;
        logic [31:0] mag;
    } s1_t;

    typedef struct packed {
        logic                  v;
        logic                  sign;
        logic                  zero;
        logic [30:0]           norm;
        logic [FP32_EXP_W-1:0] exp;
    } s2_t;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero count of a 32-bit word (zero input is don't-care)
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  cnt
);
    // highest set bit wins because it is visited last
    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 32; i++)
            if (a[i]) cnt = 5'(31 - i);
    end
endmodule

// File: rtl/axi_stream_itof.sv
// axi_stream_itof: 3-stage stallable signed int32 to binary32 converter on AXI4-stream
import axi_stream_itof_pkg::*;

module axi_stream_itof #(
    parameter int ROUND_RNE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] itof_tdata,
    input  logic        itof_tvalid,
    output logic        itof_tready,
    output logic [31:0] itof_r_tdata,
    output logic        itof_r_tvalid,
    input  logic        itof_r_tready
);
    s1_t                   s1;
    s2_t                   s2;
    logic                  en;
    logic [4:0]            lz;
    logic [FP32_FRAC_W-1:0] frac;
    logic                  g;
    logic                  st;
    logic                  up;
    logic [FP32_FRAC_W:0]  sum;
    logic [FP32_EXP_W-1:0] exp_r;
    logic [31:0]           res;

    assign en          = ~itof_r_tvalid | itof_r_tready;
    assign itof_tready = en;

    lzc32 u_lzc (.a(s1.mag), .cnt(lz));

    // stage 1: capture sign, zero flag and magnitude (0x80000000 negates to itself, valid as unsigned)
    always_ff @(posedge clk) begin
        if (rst) s1 <= '0;
        else if (en) begin
            s1.v    <= itof_tvalid;
            s1.sign <= itof_tdata[31];
            s1.zero <= itof_tdata == 32'd0;
            s1.mag  <= itof_tdata[31] ? -itof_tdata : itof_tdata;
        end
    end

    // stage 2: normalize so the leading one lands in bit 31 (dropped, it is the hidden bit)
    always_ff @(posedge clk) begin
        if (rst) s2 <= '0;
        else if (en) begin
            s2.v    <= s1.v;
            s2.sign <= s1.sign;
            s2.zero <= s1.zero;
            s2.norm <= 31'(s1.mag << lz);
            s2.exp  <= 8'(ITOF_EXP_BASE) - {3'd0, lz};
        end
    end

    // round/pack: a mantissa carry leaves the fraction at zero and bumps the exponent
    always_comb begin
        frac  = s2.norm[30:8];
        g     = s2.norm[7];
        st    = |s2.norm[6:0];
        up    = (ROUND_RNE != 0) & g & (st | frac[0]);
        sum   = {1'b0, frac} + {{FP32_FRAC_W{1'b0}}, up};
        exp_r = s2.exp + {{(FP32_EXP_W-1){1'b0}}, sum[FP32_FRAC_W]};
        res   = s2.zero ? 32'd0 : {s2.sign, exp_r, sum[FP32_FRAC_W-1:0]};
    end

    // stage 3: registered result, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            itof_r_tvalid <= 1'b0;
            itof_r_tdata  <= 32'd0;
        end else if (en) begin
            itof_r_tvalid <= s2.v;
            itof_r_tdata  <= res;
        end
    end
endmodule
